// File: rtl/ahb_rr_arbiter_if.sv
// Arbiter-side view of the AHB request/grant signals.
// master modport is the arbiter; slave modport is the fabric side.
interface ahb_rr_arbiter_if #(
    parameter int NUM_M = 5
);
    logic [NUM_M-1:0] hbusreq;
    logic [NUM_M-1:0] hlock;
    logic [1:0]       htrans;
    logic [2:0]       hburst;
    logic             hready;
    logic [NUM_M-1:0] hgrant;
    logic [NUM_M-1:0] hmaster_d;
    logic             hmastlock;

    modport master (
        input  hbusreq,
        input  hlock,
        input  htrans,
        input  hburst,
        input  hready,
        output hgrant,
        output hmaster_d,
        output hmastlock
    );

    modport slave (
        output hbusreq,
        output hlock,
        output htrans,
        output hburst,
        output hready,
        input  hgrant,
        input  hmaster_d,
        input  hmastlock
    );
endinterface

// File: rtl/ahb_rr_arbiter.sv
// Registered round-robin AHB arbiter with lock support and
// default-master parking; re-arbitrates only at legal boundaries.
module ahb_rr_arbiter #(
    parameter int NUM_M     = 5,
    parameter int DEFAULT_M = 0,
    parameter int MAX_HOLD  = 16
) (
    input  logic                HCLK,
    input  logic                HRESET,
    ahb_rr_arbiter_if.master    bus
);
    localparam int IW   = (NUM_M > 1) ? $clog2(NUM_M) : 1;
    localparam int CMAX = (MAX_HOLD > 16) ? MAX_HOLD - 1 : 15;
    localparam int CW   = $clog2(CMAX + 1);
    localparam logic [NUM_M-1:0] DEF_OH = NUM_M'(1) << DEFAULT_M;

    typedef enum logic [1:0] {
        PARK,
        OWN,
        LOCK
    } state_t;

    state_t           r_state;
    logic [NUM_M-1:0] r_grant;
    logic [NUM_M-1:0] r_mastd;
    logic             r_mastlock;
    logic [IW-1:0]    r_ptr;
    logic [IW-1:0]    r_owner;
    logic [CW-1:0]    r_cnt;

    logic             w_idle;
    logic             w_busy;
    logic             w_nonseq;
    logic             w_seq;
    logic             w_acc;
    logic [CW-1:0]    w_len;
    logic [CW-1:0]    w_cnt_nxt;
    logic             w_own_req;
    logic             w_own_lock;
    logic             w_pt;
    logic             w_hold;
    logic             w_arb;
    logic             w_found;
    logic [IW-1:0]    w_win;
    logic [IW-1:0]    w_j;
    logic [NUM_M-1:0] w_win_oh;

    assign w_idle     = (bus.htrans == 2'b00);
    assign w_busy     = (bus.htrans == 2'b01);
    assign w_nonseq   = (bus.htrans == 2'b10);
    assign w_seq      = (bus.htrans == 2'b11);
    assign w_acc      = bus.hready & (w_nonseq | w_seq);
    assign w_own_req  = |(bus.hbusreq & r_grant);
    assign w_own_lock = |(bus.hlock & r_grant);

    always_comb begin
        w_len = '0;
        unique case (bus.hburst)
            3'd0:       w_len = '0;
            3'd1:       w_len = CW'(MAX_HOLD - 1);
            3'd2, 3'd3: w_len = CW'(3);
            3'd4, 3'd5: w_len = CW'(7);
            default:    w_len = CW'(15);
        endcase
    end

    always_comb begin
        w_cnt_nxt = r_cnt;
        if (w_acc && w_nonseq)
            w_cnt_nxt = w_len;
        else if (w_acc && w_seq && r_cnt != '0)
            w_cnt_nxt = r_cnt - CW'(1);
    end

    assign w_pt = bus.hready &
                  (w_idle |
                   (w_acc & (w_cnt_nxt == '0)) |
                   (~w_own_req & ~w_seq & ~w_busy));

    // A locked owner blocks handover, including on the NONSEQ that takes the lock.
    assign w_hold = w_own_lock & ((r_state == LOCK) | (w_acc & w_nonseq));
    assign w_arb  = w_pt & ~w_hold;

    // Owner is skipped in the rotation and only considered as a last resort.
    always_comb begin
        w_found = 1'b0;
        w_win   = IW'(DEFAULT_M);
        w_j     = '0;
        for (int k = 1; k <= NUM_M; k++) begin
            w_j = IW'((int'(r_ptr) + k) % NUM_M);
            if (!w_found && bus.hbusreq[w_j] && !r_grant[w_j]) begin
                w_found = 1'b1;
                w_win   = w_j;
            end
        end
        if (!w_found && w_own_req) begin
            w_found = 1'b1;
            w_win   = r_owner;
        end
    end

    assign w_win_oh = NUM_M'(1) << w_win;

    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            r_state    <= PARK;
            r_grant    <= DEF_OH;
            r_mastd    <= DEF_OH;
            r_mastlock <= 1'b0;
            r_ptr      <= IW'(DEFAULT_M);
            r_owner    <= IW'(DEFAULT_M);
            r_cnt      <= '0;
        end else if (bus.hready) begin
            r_cnt      <= w_cnt_nxt;
            r_mastd    <= r_grant;
            r_mastlock <= w_own_lock;
            if (w_arb) begin
                r_grant <= w_win_oh;
                r_owner <= w_win;
                if (w_found)
                    r_ptr <= w_win;
                r_state <= w_found ? OWN : PARK;
            end else if (w_acc && w_nonseq && w_own_lock) begin
                r_state <= LOCK;
            end
        end
    end

    assign bus.hgrant    = r_grant;
    assign bus.hmaster_d = r_mastd;
    assign bus.hmastlock = r_mastlock;
endmodule

// File: doc/ahb_rr_arbiter.md
Name: ahb_rr_arbiter

Overview:
- Registered round-robin AHB bus arbiter for the 5-master fabric (m0..m3, mt).
- Produces one-hot address-phase grant, which drives the address/control mux select and per-master HGRANT.
- Also produces a one-hot data-phase owner, which drives the write-data mux select.
- Re-arbitrates only at legal AHB boundaries: IDLE, burst end, INCR hold limit, or requester drop. Honours HLOCK and parks on a default master when the bus is idle.

Parameters:
NUM_M, 5, number of masters; bit i = master i, bit 4 = mt.
DEFAULT_M, 0, park master index when no requests.
MAX_HOLD, 16, max accepted beats of an undefined-length (INCR) burst before forced re-arbitration.

Ports:
HCLK  in  1  bus clock, all state on rising edge.
HRESET  in  1  asynchronous active-high reset.
hbusreq  in  NUM_M  per-master bus request.
hlock  in  NUM_M  per-master lock request.
htrans  in  2  HTRANS of current address-phase owner (IDLE=0, BUSY=1, NONSEQ=2, SEQ=3).
hburst  in  3  HBURST of current owner (SINGLE=0, INCR=1, WRAP4/INCR4=2/3, WRAP8/INCR8=4/5, WRAP16/INCR16=6/7).
hready  in  1  fabric ready_final.
hgrant  out  NUM_M  one-hot address-phase grant.
hmaster_d  out  NUM_M  one-hot data-phase owner.
hmastlock  out  1  current address phase is locked.

Behaviour:
- Reset (async, immediate):
  - hgrant = hmaster_d = one-hot DEFAULT_M.
  - hmastlock = 0; rr_ptr = DEFAULT_M; beat_cnt = 0; state = PARK.
- States:
  - PARK: default master owns, no request is being served.
  - OWN: a requesting master owns.
  - LOCK: owner has hlock asserted.
- Accepted beat: hready=1 and htrans in {NONSEQ, SEQ}.
- Beat counter:
  - On an accepted NONSEQ, load burst length minus 1: SINGLE 0, INCR MAX_HOLD-1, 4-beat 3, 8-beat 7, 16-beat 15.
  - On an accepted SEQ, decrement while the counter is nonzero.
  - BUSY and hready=0 leave the counter unchanged.
- Arbitration point: an edge with hready=1 and any of:
  - htrans==IDLE.
  - Accepted beat with the post-update beat_cnt==0, i.e. last beat of a burst or SINGLE.
  - Owner's hbusreq=0 and htrans not SEQ/BUSY.
- No arbitration point is taken while the owner's hlock=1 (state LOCK).
- hready=0 freezes all state and outputs except asynchronous reset.
- Winner selection:
  - Scan masters starting at (rr_ptr+1) mod NUM_M, wrapping; the first with hbusreq=1 wins.
  - The current owner is eligible only after all others, so it wins only if it is the sole requester.
  - No requester: grant DEFAULT_M and go to PARK.
- Grant update:
  - hgrant is registered and takes the winner on the arbitration-point edge, so it is visible the next cycle.
  - rr_ptr takes the winner index unless the winner is a park.
- Transitions:
  - PARK→OWN when a winner is found.
  - OWN→LOCK when the owner's hlock=1 at an accepted NONSEQ.
  - LOCK→OWN/PARK at the first arbitration point after the owner's hlock drops.
- hmaster_d <= hgrant on every edge with hready=1, giving a 1-cycle address→data pipeline.
- hmastlock <= hlock of the granted master on hready=1 edges.
- Simultaneous requests are resolved purely by the round-robin order.
- A request arriving in the same cycle as an arbitration point is eligible.
- One-hot invariant: hgrant and hmaster_d always have exactly one bit set, including out of reset.

Test Plan:
- Reset mid-burst (HRESET pulse while m2 is owner) → hgrant=5'b00001 and hmaster_d=5'b00001 immediately, hmastlock=0.
- All five hbusreq=1 with SINGLE NONSEQ each cycle, hready=1 → grant sequence m1,m2,m3,mt,m0,m1; each grant lasts 1 cycle.
- m1 INCR4 (NONSEQ then 3 SEQ) while m3 requests → hgrant stays 5'b00010 for 4 beats, then 5'b01000 the cycle after the 4th beat.
- Same INCR4 with hready=0 for 3 cycles on beat 2 → hgrant/hmaster_d frozen; handover occurs 3 cycles later than without stalls.
- m0 INCR with MAX_HOLD=16 and mt requesting → handover to mt after exactly 16 accepted beats.
- m2 hlock=1 over two SINGLE transfers while m0 and m1 request → hgrant stays 5'b00100 and hmastlock=1 throughout; m0 (next in the scan from m2) is granted after hlock drops and the next IDLE.
